mult_share_arbiter: RTL and testbench

//   Shares one signed WIDTH x WIDTH multiplier core among NREQ requesters.
//   - Round-robin grants on a valid/ready request channel.
//   - Carries a requester ID through a LAT-stage pipeline.
//   - Returns results on a single backpressured response channel, buffered by a credit-guarded FIFO.
//   - Sits between the multiplier core (a, b, product ports) and client datapaths.

---
 rtl/mult_share_pkg.sv | 26 ++
 rtl/mult_result_fifo.sv | 60 ++++++
 rtl/mult_share_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared constants, helper function and response record layout for the
// multiplier-sharing arbiter and its result FIFO.
package mult_share_pkg;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_LAT   = 2;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_ID_W  = clog2(DEF_NREQ);
  localparam int DEF_CNT_W = clog2(DEF_DEPTH + 1);

  // Response record as stored in the FIFO: requester id above the product.
  typedef struct packed {
    logic [DEF_ID_W-1:0]      id;
    logic [2*DEF_WIDTH-1:0]   product;
  } rsp_t;

endpackage

// File: rtl/mult_result_fifo.sv
// First-word-fall-through result FIFO. Pointers wrap at DEPTH, so DEPTH
// need not be a power of two. Push and pop may happen together at any
// occupancy; a pop on an empty FIFO is ignored.
module mult_result_fifo
  import mult_share_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign not_empty = (count != '0);
  assign pop_data  = not_empty ? mem[rd_ptr] : '0;

  // Storage array; written at the write pointer on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one signed multiplier among NREQ requesters. A round-robin
// arbiter grants one request per cycle while credits remain, the operands
// and requester id flow through a LAT-stage pipeline around the multiplier
// core, and results queue in a FWFT FIFO toward a single response port.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  parameter  int LAT   = DEF_LAT,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int ID_W  = clog2(NREQ),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic [CNT_W-1:0]      outstanding
);

  localparam int RSP_W = ID_W + 2 * WIDTH;

  logic [ID_W-1:0]          rr_ptr;
  logic [CNT_W-1:0]         credit_cnt;
  logic                     grant;
  logic [ID_W-1:0]          grant_id;
  logic [ID_W:0]            search_sum;

  logic                     s1_valid;
  logic [ID_W-1:0]          s1_id;
  logic signed [WIDTH-1:0]  s1_a;
  logic signed [WIDTH-1:0]  s1_b;

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] core_product;

  logic                     push;
  logic [RSP_W-1:0]         push_data;
  logic [RSP_W-1:0]         fifo_data;
  logic                     fifo_valid;
  logic                     pop;

  // Round-robin search starting at rr_ptr; grants only while credits remain.
  always_comb begin
    grant      = 1'b0;
    grant_id   = '0;
    req_ready  = '0;
    search_sum = '0;
    if (!rst && (credit_cnt < CNT_W'(DEPTH))) begin
      for (int k = 0; k < NREQ; k++) begin
        search_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
        if (search_sum >= (ID_W + 1)'(NREQ)) search_sum = search_sum - (ID_W + 1)'(NREQ);
        if (!grant && req_valid[search_sum[ID_W-1:0]]) begin
          grant    = 1'b1;
          grant_id = search_sum[ID_W-1:0];
        end
      end
      if (grant) req_ready[grant_id] = 1'b1;
    end
  end

  // Round-robin pointer moves just past the port that won a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Credit counter: one credit per grant, returned on each accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   credit_cnt <= credit_cnt + 1'b1;
        2'b01:   credit_cnt <= credit_cnt - 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // Operand register: first pipeline stage captures the granted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= grant;
      if (grant) begin
        s1_id <= grant_id;
        s1_a  <= req_a[grant_id*WIDTH +: WIDTH];
        s1_b  <= req_b[grant_id*WIDTH +: WIDTH];
      end
    end
  end

  assign a_ext = (2*WIDTH)'(s1_a);

`ifdef MULT_ARCH_RIPPLE
  // Shift-and-add core; the sign bit of b carries negative weight.
  always_comb begin
    core_product = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_b[i]) begin
        if (i == WIDTH - 1) core_product = core_product - (a_ext <<< i);
        else                core_product = core_product + (a_ext <<< i);
      end
    end
  end
`else
  logic signed [2*WIDTH-1:0] b_ext;
  assign b_ext        = (2*WIDTH)'(s1_b);
  assign core_product = a_ext * b_ext;
`endif

  generate
    if (LAT == 1) begin : g_lat1
      assign push      = s1_valid;
      assign push_data = {s1_id, core_product};
    end else begin : g_latn
      logic [LAT:2]         pv;
      logic [ID_W-1:0]      pid   [LAT:2];
      logic [2*WIDTH-1:0]   pprod [LAT:2];

      // Result stages 2..LAT carry valid, id and product toward the FIFO.
      always_ff @(posedge clk) begin
        if (rst) begin
          pv <= '0;
        end else begin
          pv[2]    <= s1_valid;
          pid[2]   <= s1_id;
          pprod[2] <= core_product;
          for (int k = 3; k <= LAT; k++) begin
            pv[k]    <= pv[k-1];
            pid[k]   <= pid[k-1];
            pprod[k] <= pprod[k-1];
          end
        end
      end

      assign push      = pv[LAT];
      assign push_data = {pid[LAT], pprod[LAT]};
    end
  endgenerate

  mult_result_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .not_empty (fifo_valid)
  );

  assign rsp_valid                 = fifo_valid & ~rst;
  assign pop                       = rsp_valid & rsp_ready;
  assign {rsp_id, rsp_product}     = rsp_valid ? fifo_data : '0;
  assign outstanding               = rst ? '0 : credit_cnt;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter. A timestamped queue of
// granted requests serves as the reference: each grant is due on the
// response port LAT+1 cycles later, in grant order, and credits are a
// plain integer count of grants minus accepted responses.
module tb_mult_share_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic [2:0]  outstanding;

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t pend[$];
  int   m_out;
  int   m_rr;
  int   cyc;
  int   last_grant;
  int   tests;
  int   fails;

  mult_share_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .outstanding (outstanding)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] a,
                               input logic [31:0] b, input logic rr);
    rst       = r;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
  endtask

  task automatic checkOutput();
    int          g;
    int          idx;
    int          pa;
    int          pb;
    logic [3:0]  er;
    logic        ev;
    logic        popped;
    exp_t        head;
    g    = -1;
    er   = '0;
    ev   = 1'b0;
    head = '{0, 16'h0, 0};
    if (!rst) begin
      if (m_out < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        ev   = 1'b1;
        head = pend[0];
      end
    end
    checkValue("req_ready",   32'(req_ready),   32'(er));
    checkValue("rsp_valid",   32'(rsp_valid),   32'(ev));
    checkValue("rsp_id",      32'(rsp_id),      32'(head.id));
    checkValue("rsp_product", 32'(rsp_product), 32'(head.prod));
    checkValue("outstanding", 32'(outstanding), rst ? 32'd0 : 32'(m_out));
    if (rst) begin
      pend.delete();
      m_out      = 0;
      m_rr       = 0;
      last_grant = -1;
    end else begin
      popped = ev && rsp_ready;
      if (popped) void'(pend.pop_front());
      if (g >= 0) begin
        pa = $signed(req_a[g*WIDTH +: WIDTH]);
        pb = $signed(req_b[g*WIDTH +: WIDTH]);
        pend.push_back('{g, 16'(pa * pb), cyc + LAT + 1});
        m_rr = (g + 1) % NREQ;
      end
      m_out      = m_out + ((g >= 0) ? 1 : 0) - (popped ? 1 : 0);
      last_grant = g;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    logic [3:0]  cv;
    logic [31:0] ca;
    logic [31:0] cb;
    int          granted;
    tests      = 0;
    fails      = 0;
    cyc        = 0;
    m_out      = 0;
    m_rr       = 0;
    last_grant = -1;

    // Reset
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0, 1'b1);
      checkOutput();
    end

    // Single request from port 2: -5 * 10
    applyStimulus(1'b0, 4'b0100, 32'h00FB_0000, 32'h000A_0000, 1'b1);
    checkValue("t1_grant", 32'(req_ready), 32'h4);
    checkOutput();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      if (i == LAT + 1) begin
        checkValue("t1_valid",   32'(rsp_valid),   32'd1);
        checkValue("t1_id",      32'(rsp_id),      32'd2);
        checkValue("t1_product", 32'(rsp_product), 32'h0000_FFCE);
      end
      checkOutput();
    end
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    checkValue("t1_outstanding", 32'(outstanding), 32'd0);
    checkOutput();

    // All ports valid, full rate, extreme operands
    applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0, 1'b1);
    checkOutput();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h8080_7F7F, 32'h8080_7F7F, 1'b1);
      if (i == 0) checkValue("t2_first_grant", 32'(req_ready), 32'h1);
      if (i == LAT + 1) checkValue("t2_first_product", 32'(rsp_product), 32'd16129);
      if (i == LAT + 3) checkValue("t2_third_product", 32'(rsp_product), 32'd16384);
      checkOutput();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      checkOutput();
    end

    // Backpressure: credits run out, then drain resumes grants
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h0403_0201, 32'hFDFE_FF05, 1'b0);
      checkOutput();
    end
    applyStimulus(1'b0, 4'b1111, 32'h0403_0201, 32'hFDFE_FF05, 1'b0);
    checkValue("t3_full_count", 32'(outstanding), 32'(DEPTH));
    checkValue("t3_full_ready", 32'(req_ready),   32'h0);
    checkOutput();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h0403_0201, 32'hFDFE_FF05, 1'b1);
      checkOutput();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      checkOutput();
    end

    // Simultaneous grant and pop at 3 and at 4 outstanding
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h1122_3344, 32'h0506_0708, 1'b0);
      checkOutput();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
      checkOutput();
    end
    applyStimulus(1'b0, 4'b1111, 32'h1122_3344, 32'h0506_0708, 1'b1);
    checkValue("t4_pop_at3",   32'(rsp_valid), 32'd1);
    checkValue("t4_grant_at3", 32'(req_ready != 4'b0000), 32'd1);
    checkOutput();
    applyStimulus(1'b0, 4'b1111, 32'h1122_3344, 32'h0506_0708, 1'b0);
    checkValue("t4_still3", 32'(outstanding), 32'd3);
    checkOutput();
    applyStimulus(1'b0, 4'b1111, 32'h1122_3344, 32'h0506_0708, 1'b1);
    checkValue("t4_at4",       32'(outstanding), 32'd4);
    checkValue("t4_no_grant4", 32'(req_ready),   32'h0);
    checkOutput();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      checkOutput();
    end

    // Reset with results in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h7F80_0102, 32'h0203_0405, 1'b0);
      checkOutput();
    end
    applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0, 1'b0);
    checkOutput();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      checkValue("t5_no_rsp", 32'(rsp_valid), 32'd0);
      checkOutput();
    end
    applyStimulus(1'b0, 4'b1111, 32'h0909_0909, 32'hF7F7_F7F7, 1'b1);
    checkValue("t5_outstanding", 32'(outstanding), 32'd0);
    checkValue("t5_rr_zero",     32'(req_ready),   32'h1);
    checkOutput();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      checkOutput();
    end

    // Randomized operands, valids and backpressure
    cv      = '0;
    ca      = '0;
    cb      = '0;
    granted = 0;
    for (int it = 0; it < 4000 && granted < 200; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cv[i]) begin
          cv[i]               = 1'($urandom_range(0, 1));
          ca[i*WIDTH +: WIDTH] = 8'($urandom);
          cb[i*WIDTH +: WIDTH] = 8'($urandom);
        end
      end
      applyStimulus(1'b0, cv, ca, cb, ($urandom_range(0, 3) != 0));
      checkOutput();
      if (last_grant >= 0) begin
        cv[last_grant] = 1'b0;
        granted++;
      end
    end
    checkValue("rand_grants", 32'(granted), 32'd200);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
      checkOutput();
    end
    checkValue("final_outstanding", 32'(outstanding), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
